rv_timer_cmp_sched: RTL and testbench



---
 rtl/rv_timer_sched_pkg.sv | 16 +
 rtl/rv_timer_min_fold.sv | 30 +++
 rtl/rv_timer_cmp_sched.sv | 147 ++++++++++++++
 tb/tb_rv_timer_cmp_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_timer_sched_pkg.sv
// Shared types for the time-multiplexed compare scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_timer_sched_pkg;

    localparam logic [63:0] CmpInit = '1;

    typedef struct packed {
        logic [63:0] cmp;
        logic        armed;
        logic        expired;
    } sched_slot_t;

    localparam sched_slot_t SlotInit = '{cmp: CmpInit, armed: 1'b0, expired: 1'b0};

endpackage

// File: rtl/rv_timer_min_fold.sv
// Folds one candidate slot into the running minimum of a sweep.
// Latency: purely combinational.
// Backpressure: none.
// Ports: acc_* = accumulator so far, cand_* = slot under the scanner,
//        fold_* = updated accumulator (candidate wins only on strictly smaller cmp).
module rv_timer_min_fold #(
    parameter int SlotW = 2
) (
    input  logic             acc_valid_i,
    input  logic [SlotW-1:0] acc_slot_i,
    input  logic [63:0]      acc_cmp_i,
    input  logic             cand_valid_i,
    input  logic [SlotW-1:0] cand_slot_i,
    input  logic [63:0]      cand_cmp_i,
    output logic             fold_valid_o,
    output logic [SlotW-1:0] fold_slot_o,
    output logic [63:0]      fold_cmp_o
);

    logic take;

    // Strict less-than: slots are visited in ascending order, so on a tie
    // the earlier (lower index) slot is kept.
    assign take = cand_valid_i && (!acc_valid_i || (cand_cmp_i < acc_cmp_i));

    assign fold_valid_o = acc_valid_i | cand_valid_i;
    assign fold_slot_o  = take ? cand_slot_i : acc_slot_i;
    assign fold_cmp_o   = take ? cand_cmp_i  : acc_cmp_i;

endmodule

// File: rtl/rv_timer_cmp_sched.sv
// Round-robin compare scheduler: NumSlots 64-bit deadlines share one comparator against mtime.
// Latency: expiry seen 1..NumSlots cycles after mtime crosses; next_* lags by at most one sweep.
// Backpressure: req/gnt write port, registered grant, deferred one cycle if the scanner is due on the slot.
// Ports: mtime_i timer value; wr_* slot write port; clr_i expiry acknowledge;
//        expired_o sticky flags; next_* earliest armed deadline of the last sweep.
module rv_timer_cmp_sched
    import rv_timer_sched_pkg::*;
#(
    parameter  int NumSlots = 4,
    localparam int SlotW    = $clog2(NumSlots)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [63:0]         mtime_i,
    input  logic                wr_req_i,
    output logic                wr_gnt_o,
    input  logic [SlotW-1:0]    wr_slot_i,
    input  logic [63:0]         wr_cmp_i,
    input  logic                wr_arm_i,
    input  logic [NumSlots-1:0] clr_i,
    output logic [NumSlots-1:0] expired_o,
    output logic                next_valid_o,
    output logic [SlotW-1:0]    next_slot_o,
    output logic [63:0]         next_cmp_o
);

    localparam logic [SlotW-1:0] LastSlot = SlotW'(NumSlots - 1);

    sched_slot_t      slots_q [NumSlots];
    sched_slot_t      slots_d [NumSlots];
    logic [SlotW-1:0] ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic             acc_valid_q, acc_valid_d;
    logic [SlotW-1:0] acc_slot_q, acc_slot_d;
    logic [63:0]      acc_cmp_q, acc_cmp_d;
    logic             next_valid_q, next_valid_d;
    logic [SlotW-1:0] next_slot_q, next_slot_d;
    logic [63:0]      next_cmp_q, next_cmp_d;

    sched_slot_t      cur;
    logic             hit;
    logic             fold_valid;
    logic [SlotW-1:0] fold_slot;
    logic [63:0]      fold_cmp;

    assign cur   = slots_q[ptr_q];
    assign hit   = cur.armed && (mtime_i >= cur.cmp);
    assign ptr_d = (ptr_q == LastSlot) ? '0 : ptr_q + 1'b1;

    // The write lands at the end of the grant cycle, when ptr == ptr_d.
    // Refusing the grant when ptr_d hits the target slot keeps a write and
    // the scanner's compare of that slot from ever sharing a cycle.
    assign gnt_d = wr_req_i && !gnt_q && (ptr_d != wr_slot_i);

    always_comb begin
        slots_d = slots_q;
        for (int i = 0; i < NumSlots; i++) begin
            if (clr_i[i]) begin
                slots_d[i].expired = 1'b0;
            end
        end
        // Applied after the clears so a same-cycle expiry wins over clr_i.
        if (hit) begin
            slots_d[ptr_q].expired = 1'b1;
            slots_d[ptr_q].armed   = 1'b0;
        end
        if (gnt_q) begin
            slots_d[wr_slot_i] = '{cmp: wr_cmp_i, armed: wr_arm_i, expired: 1'b0};
        end
    end

    // A slot expiring this cycle is no longer a pending deadline.
    rv_timer_min_fold #(.SlotW(SlotW)) u_fold (
        .acc_valid_i  (acc_valid_q),
        .acc_slot_i   (acc_slot_q),
        .acc_cmp_i    (acc_cmp_q),
        .cand_valid_i (cur.armed && !hit),
        .cand_slot_i  (ptr_q),
        .cand_cmp_i   (cur.cmp),
        .fold_valid_o (fold_valid),
        .fold_slot_o  (fold_slot),
        .fold_cmp_o   (fold_cmp)
    );

    always_comb begin
        acc_valid_d  = fold_valid;
        acc_slot_d   = fold_slot;
        acc_cmp_d    = fold_cmp;
        next_valid_d = next_valid_q;
        next_slot_d  = next_slot_q;
        next_cmp_d   = next_cmp_q;
        if (ptr_q == LastSlot) begin
            next_valid_d = fold_valid;
            next_slot_d  = fold_slot;
            next_cmp_d   = fold_cmp;
            acc_valid_d  = 1'b0;
            acc_slot_d   = '0;
            acc_cmp_d    = CmpInit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                slots_q[i] <= SlotInit;
            end
            ptr_q        <= '0;
            gnt_q        <= 1'b0;
            acc_valid_q  <= 1'b0;
            acc_slot_q   <= '0;
            acc_cmp_q    <= CmpInit;
            next_valid_q <= 1'b0;
            next_slot_q  <= '0;
            next_cmp_q   <= CmpInit;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                slots_q[i] <= slots_d[i];
            end
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            acc_valid_q  <= acc_valid_d;
            acc_slot_q   <= acc_slot_d;
            acc_cmp_q    <= acc_cmp_d;
            next_valid_q <= next_valid_d;
            next_slot_q  <= next_slot_d;
            next_cmp_q   <= next_cmp_d;
        end
    end

    always_comb begin
        expired_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            expired_o[i] = slots_q[i].expired;
        end
    end

    assign wr_gnt_o     = gnt_q;
    assign next_valid_o = next_valid_q;
    assign next_slot_o  = next_slot_q;
    assign next_cmp_o   = next_cmp_q;

    // A pending request that is not being granted at this edge must still
    // be present next cycle; the requester may drop it during the grant cycle.
    a_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wr_req_i && !gnt_q && !gnt_d) |=> wr_req_i);

endmodule

// File: tb/tb_rv_timer_cmp_sched.sv
module tb_rv_timer_cmp_sched;

    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   mtime_i;
    logic          wr_req_i;
    logic          wr_gnt_o;
    logic [SW-1:0] wr_slot_i;
    logic [63:0]   wr_cmp_i;
    logic          wr_arm_i;
    logic [N-1:0]  clr_i;
    logic [N-1:0]  expired_o;
    logic          next_valid_o;
    logic [SW-1:0] next_slot_o;
    logic [63:0]   next_cmp_o;

    rv_timer_cmp_sched #(.NumSlots(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mtime_i      (mtime_i),
        .wr_req_i     (wr_req_i),
        .wr_gnt_o     (wr_gnt_o),
        .wr_slot_i    (wr_slot_i),
        .wr_cmp_i     (wr_cmp_i),
        .wr_arm_i     (wr_arm_i),
        .clr_i        (clr_i),
        .expired_o    (expired_o),
        .next_valid_o (next_valid_o),
        .next_slot_o  (next_slot_o),
        .next_cmp_o   (next_cmp_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: slot arrays plus the list of deadlines seen this sweep.
    logic [63:0] m_cmp [N];
    bit          m_armed [N];
    logic [N-1:0] m_exp;
    int          m_ptr;
    bit          m_gnt;
    bit          m_nv;
    int          m_ns;
    logic [63:0] m_nc;
    int          sweep_s [$];
    logic [63:0] sweep_c [$];

    bit rnd_en = 1'b0;
    int m_inc  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cmp[i]   = '1;
            m_armed[i] = 1'b0;
        end
        m_exp = '0;
        m_ptr = 0;
        m_gnt = 1'b0;
        m_nv  = 1'b0;
        m_ns  = 0;
        m_nc  = '1;
        sweep_s.delete();
        sweep_c.delete();
    endtask

    task automatic model_update();
        int          p;
        bit          g;
        bit          hit;
        logic [63:0] best;
        int          bslot;
        p   = m_ptr;
        g   = m_gnt;
        hit = m_armed[p] && (mtime_i >= m_cmp[p]);
        if (m_armed[p] && !hit) begin
            sweep_s.push_back(p);
            sweep_c.push_back(m_cmp[p]);
        end
        if (p == N - 1) begin
            // Earliest deadline first, then lowest slot number among equals.
            best  = '1;
            bslot = N;
            foreach (sweep_c[i]) if (sweep_c[i] < best) best = sweep_c[i];
            foreach (sweep_s[i]) if (sweep_c[i] == best && sweep_s[i] < bslot) bslot = sweep_s[i];
            m_nv = (sweep_s.size() != 0);
            m_ns = m_nv ? bslot : 0;
            m_nc = m_nv ? best : '1;
            sweep_s.delete();
            sweep_c.delete();
        end
        m_exp = m_exp & ~clr_i;
        if (hit) begin
            m_exp[p]   = 1'b1;
            m_armed[p] = 1'b0;
        end
        if (g) begin
            m_cmp[wr_slot_i]   = wr_cmp_i;
            m_armed[wr_slot_i] = wr_arm_i;
            m_exp[wr_slot_i]   = 1'b0;
        end
        m_gnt = wr_req_i && !g && (((p + 1) % N) != int'(wr_slot_i));
        m_ptr = (p + 1) % N;
    endtask

    task automatic check_all();
        chk("expired",    64'(expired_o),    64'(m_exp));
        chk("next_valid", 64'(next_valid_o), 64'(m_nv));
        chk("next_slot",  64'(next_slot_o),  64'(m_ns));
        chk("next_cmp",   next_cmp_o,        m_nc);
        chk("wr_gnt",     64'(wr_gnt_o),     64'(m_gnt));
        chk("ptr",        64'(dut.ptr_q),    64'(m_ptr));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        else       model_reset();
        @(negedge clk);
        check_all();
        clr_i = '0;
        if (rnd_en) begin
            if ($urandom_range(0, 7) == 0) clr_i = N'($urandom);
            m_inc = $urandom_range(0, 3);
        end
        mtime_i = mtime_i + 64'(m_inc);
    endtask

    task automatic do_write(input int slot, input logic [63:0] cmp, input bit arm, output int waited);
        int exp_wait;
        exp_wait  = (((m_ptr + 1) % N) == slot) ? 2 : 1;
        wr_slot_i = SW'(slot);
        wr_cmp_i  = cmp;
        wr_arm_i  = arm;
        wr_req_i  = 1'b1;
        waited    = 0;
        do begin
            step();
            waited++;
        end while (!wr_gnt_o && waited < 6);
        chk("wr_gnt_wait", 64'(waited), 64'(exp_wait));
        wr_req_i = 1'b0;
        step();
    endtask

    initial begin
        int          w;
        int          lat;
        bit          seen;
        logic [63:0] pres;

        rst_n     = 1'b0;
        mtime_i   = '0;
        wr_req_i  = 1'b0;
        wr_slot_i = '0;
        wr_cmp_i  = '0;
        wr_arm_i  = 1'b0;
        clr_i     = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset: pointer walks 1,2,3,0,1,... and no grant appears.
        repeat (6) step();

        // Single deadline at 100 with mtime ramping from 90.
        mtime_i = 64'd90;
        m_inc   = 1;
        do_write(2, 64'd100, 1'b1, w);
        lat  = 0;
        seen = 1'b0;
        for (int t = 0; t < 24 && !seen; t++) begin
            pres = mtime_i;
            step();
            if (pres >= 64'd100) lat++;
            seen = expired_o[2];
        end
        chk("exp2_rise", 64'(seen), 64'd1);
        chk("exp2_latency", 64'(lat >= 1 && lat <= N), 64'd1);
        m_inc = 0;
        repeat (3) step();
        chk("exp2_sticky", 64'(expired_o[2]), 64'd1);
        chk("slot2_disarmed", 64'(dut.slots_q[2].armed), 64'd0);
        clr_i = N'(4'b0100);
        step();
        chk("exp2_cleared", 64'(expired_o[2]), 64'd0);

        // Earliest deadline with a tie between slots 1 and 3.
        do_write(0, 64'd500, 1'b1, w);
        do_write(1, 64'd300, 1'b1, w);
        do_write(3, 64'd300, 1'b1, w);
        repeat (2 * N) step();
        chk("min_valid", 64'(next_valid_o), 64'd1);
        chk("min_slot_tie", 64'(next_slot_o), 64'd1);
        chk("min_cmp", next_cmp_o, 64'd300);
        do_write(1, 64'd300, 1'b0, w);
        repeat (2 * N) step();
        chk("min_slot_after_disarm", 64'(next_slot_o), 64'd3);

        // Write aimed at the slot the scanner visits next: grant deferred.
        for (int t = 0; t < 2 * N && m_ptr != 1; t++) step();
        do_write(2, mtime_i + 64'd5000, 1'b1, w);
        chk("defer_wait", 64'(w), 64'd2);
        repeat (2 * N) step();
        chk("defer_no_spurious", 64'(expired_o[2]), 64'd0);
        chk("defer_committed", dut.slots_q[2].cmp, mtime_i + 64'd5000);

        // Expiry and acknowledge on the same slot in the same cycle.
        for (int t = 0; t < 2 * N && m_ptr != 0; t++) step();
        mtime_i = 64'd500;
        clr_i   = N'(4'b0001);
        step();
        chk("set_beats_clr", 64'(expired_o[0]), 64'd1);

        // Rewriting an expired slot clears its flag.
        step();
        chk("exp0_before_rewrite", 64'(expired_o[0]), 64'd1);
        do_write(0, mtime_i + 64'd1000, 1'b1, w);
        chk("rewrite_clears", 64'(expired_o[0]), 64'd0);

        // Reset while a deferred request is still waiting.
        for (int t = 0; t < 2 * N && m_ptr != 1; t++) step();
        wr_slot_i = SW'(2);
        wr_cmp_i  = 64'd77;
        wr_arm_i  = 1'b1;
        wr_req_i  = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_expired", 64'(expired_o), 64'd0);
        chk("rst_next_valid", 64'(next_valid_o), 64'd0);
        chk("rst_next_slot", 64'(next_slot_o), 64'd0);
        chk("rst_next_cmp", next_cmp_o, '1);
        chk("rst_gnt", 64'(wr_gnt_o), 64'd0);
        step();
        wr_req_i = 1'b0;
        step();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            chk("no_gnt_after_reset", 64'(wr_gnt_o), 64'd0);
        end

        // Randomized writes, clears and mtime increments against the model.
        rnd_en = 1'b1;
        for (int it = 0; it < 80; it++) begin
            do_write($urandom_range(0, N - 1),
                     mtime_i + 64'($urandom_range(0, 100)) - 64'd30,
                     $urandom_range(0, 3) != 0, w);
            repeat ($urandom_range(0, 6)) step();
        end
        rnd_en = 1'b0;
        m_inc  = 0;
        repeat (2 * N) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
